// File: rtl/axi_receive.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_receive: reassembles BUS_WIDTH-bit beats (LS beat first) into one     |
// | DATA_WIDTH-bit word held in a single-entry buffer until consumed.         |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module axi_receive #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_WIDTH-1:0]  axi_packet,
  input  logic                  valid_pack,
  output logic                  device_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  consumer_rdy
);

  localparam int BEATS   = (DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int CNT_W   = $clog2(BEATS) + 1;
  localparam int ASM_W   = BEATS * BUS_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [ASM_W-1:0] r_asm;
  logic             w_xfer;
  logic             w_last;
  logic             w_unused_pad;

  assign w_xfer = valid_pack && (r_state != S_HOLD);
  assign w_last = (r_beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_RECV: begin
        if (w_xfer) begin
          w_next_state = w_last ? S_HOLD : S_RECV;
        end
      end
      S_HOLD: begin
        if (consumer_rdy) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    device_rdy = (r_state != S_HOLD);
    data_valid = (r_state == S_HOLD);
  end

  // Beat k lands in slice k; stale upper slices are overwritten as the next word arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_asm      <= '0;
    end else if (w_xfer) begin
      for (int k = 0; k < BEATS; k++) begin
        if (r_beat_cnt == CNT_W'(k)) begin
          r_asm[k*BUS_WIDTH +: BUS_WIDTH] <= axi_packet;
        end
      end
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

  assign data_out = r_asm[DATA_WIDTH-1:0];

  // Padding bits above DATA_WIDTH are captured but deliberately never output.
  assign w_unused_pad = ^{1'b0, r_asm};

endmodule
`default_nettype wire

// File: tb/tb_axi_receive.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_receive: checks a 1-beat (32/32) and a 3-beat (32/80) receiver     |
// | against a queue-free arithmetic word model. Revision: 1.0                 |
// +----------------------------------------------------------------------------+
module tb_axi_receive;

  logic        clk;
  logic        rst;
  logic [31:0] pkt32, pkt80;
  logic        vld32, vld80;
  logic        cons32, cons80;
  logic        rdy32, rdy80;
  logic        dv32, dv80;
  logic [31:0] dout32;
  logic [79:0] dout80;

  int n_chk;
  int n_fail;

  // Model state: held flag, beats collected, accumulated partial word, held word
  bit          h0, h1;
  int          n0, n1;
  logic [95:0] a0, a1, w0, w1;

  axi_receive #(.BUS_WIDTH(32), .DATA_WIDTH(32)) u_rx32 (
    .clk(clk), .rst(rst), .axi_packet(pkt32), .valid_pack(vld32),
    .device_rdy(rdy32), .data_out(dout32), .data_valid(dv32),
    .consumer_rdy(cons32)
  );

  axi_receive #(.BUS_WIDTH(32), .DATA_WIDTH(80)) u_rx80 (
    .clk(clk), .rst(rst), .axi_packet(pkt80), .valid_pack(vld80),
    .device_rdy(rdy80), .data_out(dout80), .data_valid(dv80),
    .consumer_rdy(cons80)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void mstep(input int beats, input int dw, input bit r, input bit v,
                                input logic [31:0] p, input bit c, inout bit held,
                                inout int n, inout logic [95:0] acc, inout logic [95:0] word);
    if (r) begin
      held = 0; n = 0; acc = '0; word = '0;
    end else if (held) begin
      if (c) held = 0;
    end else if (v) begin
      acc = acc | ({64'b0, p} << (32 * n));
      n++;
      if (n == beats) begin
        word = acc & ((96'b1 << dw) - 96'b1);
        held = 1; n = 0; acc = '0;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit v32, input logic [31:0] p32, input bit c32,
                     input bit v80, input logic [31:0] p80, input bit c80);
    rst = r; vld32 = v32; pkt32 = p32; cons32 = c32;
    vld80 = v80; pkt80 = p80; cons80 = c80;
    @(posedge clk);
    #1;
    mstep(1, 32, r, v32, p32, c32, h0, n0, a0, w0);
    mstep(3, 80, r, v80, p80, c80, h1, n1, a1, w1);
    chk("rdy32", {95'b0, rdy32}, {95'b0, !h0});
    chk("dv32",  {95'b0, dv32},  {95'b0, h0});
    chk("rdy80", {95'b0, rdy80}, {95'b0, !h1});
    chk("dv80",  {95'b0, dv80},  {95'b0, h1});
    if (h0 || r) chk("dout32", {64'b0, dout32}, w0);
    if (h1 || r) chk("dout80", {16'b0, dout80}, w1);
  endtask

  task automatic s80(input bit v, input logic [31:0] p, input bit c);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, v, p, c);
  endtask

  task automatic s32(input bit v, input logic [31:0] p, input bit c);
    cyc(1'b0, v, p, c, 1'b0, 32'h0, 1'b0);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] p;
    bit          c;
    bit          rdy;
    bit          dv;
    logic [31:0] d;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int   pulses;
    bit   prev_dv;
    logic [79:0] held_word;

    n_chk = 0; n_fail = 0;
    h0 = 0; h1 = 0; n0 = 0; n1 = 0; a0 = '0; a1 = '0; w0 = '0; w1 = '0;

    tbl[0]  = '{1, 32'h7B, 1, 0, 1, 32'd123};
    tbl[1]  = '{0, 32'h0,  1, 1, 0, 32'd0};
    tbl[2]  = '{1, 32'd69, 1, 0, 1, 32'd69};
    tbl[3]  = '{1, 32'd70, 1, 1, 0, 32'd0};
    tbl[4]  = '{1, 32'd70, 1, 0, 1, 32'd70};
    tbl[5]  = '{1, 32'd71, 1, 1, 0, 32'd0};
    tbl[6]  = '{1, 32'd71, 1, 0, 1, 32'd71};
    tbl[7]  = '{0, 32'h0,  1, 1, 0, 32'd0};
    tbl[8]  = '{0, 32'h0,  1, 1, 0, 32'd0};
    tbl[9]  = '{1, 32'd5,  0, 0, 1, 32'd5};
    tbl[10] = '{1, 32'd6,  0, 0, 1, 32'd5};
    tbl[11] = '{1, 32'd6,  1, 1, 0, 32'd0};
    tbl[12] = '{1, 32'd6,  0, 0, 1, 32'd6};
    tbl[13] = '{0, 32'h0,  1, 1, 0, 32'd0};

    // Reset values
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("reset_dout80", {16'b0, dout80}, 96'h0);
    chk("reset_rdy80", {95'b0, rdy80}, 96'h1);

    // Single-beat receiver from the table
    pulses = 0; prev_dv = 0;
    for (int i = 0; i < 14; i++) begin
      s32(tbl[i].v, tbl[i].p, tbl[i].c);
      chk($sformatf("tbl%0d_rdy", i), {95'b0, rdy32}, {95'b0, tbl[i].rdy});
      chk($sformatf("tbl%0d_dv", i), {95'b0, dv32}, {95'b0, tbl[i].dv});
      if (tbl[i].dv) chk($sformatf("tbl%0d_data", i), {64'b0, dout32}, {64'b0, tbl[i].d});
      if (i >= 2 && i <= 7 && dv32 && !prev_dv) pulses++;
      prev_dv = dv32;
    end
    chk("pulse_count_69_71", 96'(pulses), 96'd3);

    // Back-to-back 3-beat word, padding discarded
    s80(1, 32'h1111_1111, 0);
    chk("b2b_no_early_dv1", {95'b0, dv80}, 96'h0);
    s80(1, 32'h2222_2222, 0);
    chk("b2b_no_early_dv2", {95'b0, dv80}, 96'h0);
    s80(1, 32'hFFFF_3333, 0);
    chk("b2b_word", {16'b0, dout80}, {16'b0, 80'h3333_2222_2222_1111_1111});
    chk("b2b_dv", {95'b0, dv80}, 96'h1);

    // Long hold with a pending beat on the bus
    held_word = dout80;
    for (int i = 0; i < 20; i++) begin
      s80(1, 32'hAAAA_5555, 0);
      chk("hold_rdy", {95'b0, rdy80}, 96'h0);
      chk("hold_stable", {16'b0, dout80}, {16'b0, held_word});
    end
    s80(1, 32'hAAAA_5555, 1);
    chk("release_rdy", {95'b0, rdy80}, 96'h1);
    s80(1, 32'hAAAA_5555, 0);
    s80(1, 32'hBBBB_BBBB, 0);
    s80(1, 32'hCCCC_CCCC, 0);
    chk("pending_beat0", {16'b0, dout80}, {16'b0, 80'hCCCC_BBBB_BBBB_AAAA_5555});
    s80(0, 32'h0, 1);

    // Beats separated by 5-cycle gaps
    for (int b = 0; b < 3; b++) begin
      s80(1, (b == 0) ? 32'h1111_1111 : (b == 1) ? 32'h2222_2222 : 32'hFFFF_3333, 0);
      if (b < 2) begin
        for (int g = 0; g < 5; g++) begin
          s80(0, 32'hDEAD_DEAD, 1);
          chk("gap_no_dv", {95'b0, dv80}, 96'h0);
        end
      end
    end
    chk("gap_word", {16'b0, dout80}, {16'b0, 80'h3333_2222_2222_1111_1111});
    s80(0, 32'h0, 1);

    // Reset after two beats, then a fresh word
    s80(1, 32'hDEAD_BEEF, 0);
    s80(1, 32'hCAFE_F00D, 0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("midrst_dout", {16'b0, dout80}, 96'h0);
    s80(1, 32'd1, 0);
    s80(1, 32'd2, 0);
    chk("midrst_no_early_dv", {95'b0, dv80}, 96'h0);
    s80(1, 32'd3, 0);
    chk("midrst_word", {16'b0, dout80}, {16'b0, 80'h0003_0000_0002_0000_0001});
    chk("midrst_dv", {95'b0, dv80}, 96'h1);
    s80(0, 32'h0, 1);

    // Random traffic on both receivers against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0),
          1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
